keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans the 3x4 board keypad and delivers debounced key codes to the game-state logic over the existing `key_data` interface. It is the producer side of that interface: it drives the keypad columns, senses the rows, debounces presses and releases, and outputs a stable code plus a one-cycle `key_valid` strobe. It sits between the keypad pins and the game-state block, and is gated by `enable` (held low while on the main screen).

Parameters:
SCAN_DIV, 25000, clk cycles per column slot (scan tick period); legal range >= 4
DEB_FRAMES, 4, consecutive identical full-scan frames needed to accept a press or release; legal range 2..15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scanning and debouncing active; 0 = freeze and force no-key
key_row  input  4  keypad row sense, active-high, asynchronous to clk
key_col  output  3  one-hot active-high column drive
key_data  output  4  debounced key code: 0 = none, 1..9 = digits 1..9, 10 = '*', 11 = '0', 12 = '#'
key_valid  output  1  one-clk pulse when a new press is accepted
multi_key  output  1  high while the last completed frame saw more than one key

Behaviour:
- Reset (async, rst_n=0): key_col=3'b001, col index 0, prescaler 0, key_data=0, key_valid=0, multi_key=0, FSM=IDLE, debounce count 0, frame accumulator cleared, synchroniser flops 0.
- Synchroniser: key_row passes through two flops before any use. SCAN_DIV>=4 guarantees the synchronised rows settle before sampling.
- Prescaler: counts 0..SCAN_DIV-1. `tick` asserts for one clk when count = SCAN_DIV-1, then the count wraps to 0.
- On each tick:
  - Sample the synchronised rows for the current column into the frame accumulator.
  - Advance the column 0→1→2→0 and update key_col one-hot on the same edge.
- Frame end: the tick that samples column 2. The frame code is evaluated from the accumulator plus the current sample:
  - exactly one row/col hit at (r,c): code = 3r+c+1 for r<3; r=3 gives c0→10, c1→11, c2→12.
  - no hit: code NONE (0).
  - two or more hits: code MULTI. multi_key is set to 1 on a MULTI frame and cleared at the end of the next non-MULTI frame.
  - The accumulator is cleared for the next frame.
- FSM advances only on frame-end ticks. Registered outputs change 1 clk after the frame-end tick.
  - IDLE: single key K → cand=K, cnt=1, go DEB_PRESS. NONE or MULTI → stay.
  - DEB_PRESS: frame==cand → cnt+1. When cnt+1 = DEB_FRAMES → PRESSED, key_data=cand, key_valid=1 for one clk. Otherwise (frame≠cand) → IDLE, cnt=0.
  - PRESSED: frame==cand → stay. Otherwise (NONE, another key, MULTI) → DEB_REL, cnt=1.
  - DEB_REL: frame≠cand → cnt+1. When cnt+1 = DEB_FRAMES → IDLE, key_data=0. frame==cand → back to PRESSED, cnt=0, no new key_valid.
- A second key pressed while one is held only releases the first. The new key needs a full release to IDLE followed by a fresh press; no roll-over.
- Press latency: DEB_FRAMES frames × 3·SCAN_DIV clks, +1 clk, measured from the first frame fully containing the press. Release latency is the same.
- enable=0, on the same clk and whatever the state: FSM→IDLE, key_data=0, key_valid=0, cnt=0, accumulator cleared, multi_key=0, prescaler held. key_col holds its value. Scanning resumes from the held column when enable returns to 1.
- cnt is 4 bits and saturates; it cannot wrap.

Decomposition:
- Package `keypad_pkg`:
  - key code constants KEY_NONE=0, KEY_STAR=10, KEY_ZERO=11, KEY_HASH=12
  - internal MULTI marker 4'hF (never driven on key_data)
  - FSM state enum {IDLE, DEB_PRESS, PRESSED, DEB_REL}
- One natural sub-module, `key_debounce_fsm`: takes frame_valid and frame_code, produces key_data, key_valid, cnt. The parent keeps the prescaler, column scan, synchroniser and frame decoder.

Test Plan:
(All with SCAN_DIV=4, DEB_FRAMES=3 unless noted. The bench models key_row combinationally from key_col and the pressed-key set; one frame = 12 clks.)
- Reset/idle: release rst_n with no key → key_col cycles 001→010→100 every 4 clks; key_data=0 and key_valid=0 for 200 clks.
- Clean press '5' (r1,c1), held from a frame boundary → after 3 frame-ends key_data=5 and key_valid is high for exactly 1 clk. Release → key_data returns to 0 three frame-ends later; no further pulses.
- Bounce: '9' toggles every frame for 5 frames, then is held → no key_valid during bouncing; exactly one pulse with key_data=9 three stable frames after holding starts.
- Row 3 codes: press '*', '0', '#' in turn, each with full release → key_data=10, 11, 12 respectively, one pulse each.
- Multi/roll-over: hold '1', then add '3' → multi_key=1; key_data goes 1→0 after 3 frames; releasing '1' while '3' is held gives key_data=3 with one new pulse.
- Reset/enable mid-operation: drop enable to 0 in DEB_PRESS → key_data=0 next clk and no pulse; assert rst_n=0 asynchronously while PRESSED → outputs at reset values with no clk edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM states and the frame decoder for the keypad scanner.
package keypad_pkg;

    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_ZERO  = 4'd11;
    localparam logic [3:0] KEY_HASH  = 4'd12;
    // Internal marker for a frame with two or more hits; never driven on key_data.
    localparam logic [3:0] KEY_MULTI = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StPressed,
        StDebRel
    } key_state_e;

    // hits bit index is 3*row + col; a single hit maps to code index+1.
    function automatic logic [3:0] frame_code(input logic [11:0] hits);
        logic [3:0]  code;
        int unsigned n;
        code = KEY_NONE;
        n    = 0;
        for (int i = 0; i < 12; i++) begin
            if (hits[i]) begin
                n++;
                case (i)
                    9:       code = KEY_STAR;
                    10:      code = KEY_ZERO;
                    11:      code = KEY_HASH;
                    default: code = 4'(i + 1);
                endcase
            end
        end
        if (n > 1) begin
            code = KEY_MULTI;
        end
        return code;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Frame-rate debounce of decoded key codes; emits a stable code and a one-clk press strobe.
module key_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       frame_valid,
    input  logic [3:0] frame_code,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic [3:0] cnt
);

    key_state_e state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] key_data_q, key_data_d;
    logic       key_valid_q, key_valid_d;
    logic [3:0] cnt_inc;

    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        if (!enable) begin
            state_d    = StIdle;
            cand_d     = KEY_NONE;
            cnt_d      = 4'd0;
            key_data_d = KEY_NONE;
        end else if (frame_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_code != KEY_NONE && frame_code != KEY_MULTI) begin
                        cand_d  = frame_code;
                        cnt_d   = 4'd1;
                        state_d = StDebPress;
                    end
                end
                StDebPress: begin
                    if (frame_code == cand_q) begin
                        if (cnt_inc == 4'(DEB_FRAMES)) begin
                            state_d     = StPressed;
                            key_data_d  = cand_q;
                            key_valid_d = 1'b1;
                            cnt_d       = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end
                end
                StPressed: begin
                    // Any other frame (none, other key, multi) starts a release.
                    if (frame_code != cand_q) begin
                        state_d = StDebRel;
                        cnt_d   = 4'd1;
                    end
                end
                StDebRel: begin
                    if (frame_code != cand_q) begin
                        if (cnt_inc == 4'(DEB_FRAMES)) begin
                            state_d    = StIdle;
                            key_data_d = KEY_NONE;
                            cnt_d      = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = StPressed;
                        cnt_d   = 4'd0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cand_q      <= KEY_NONE;
            cnt_q       <= 4'd0;
            key_data_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: column drive, row synchroniser, frame decode and debounced key output.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 25000,
    parameter int unsigned DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       multi_key
);

    localparam int unsigned PresW = $clog2(SCAN_DIV);

    logic [PresW-1:0] presc_q;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [1:0]       col_idx_q;
    logic [2:0]       key_col_q;
    logic [11:0]      acc_q;
    logic             multi_q;

    logic             tick;
    logic             frame_end;
    logic [11:0]      cur_hits;
    logic [11:0]      frame_hits;
    logic [3:0]       code;
    logic [3:0]       deb_cnt;

    assign tick      = enable && (presc_q == PresW'(SCAN_DIV - 1));
    assign frame_end = tick && (col_idx_q == 2'd2);

    always_comb begin
        cur_hits = '0;
        for (int r = 0; r < 4; r++) begin
            case (col_idx_q)
                2'd0:    cur_hits[3*r]     = row_sync_q[r];
                2'd1:    cur_hits[3*r + 1] = row_sync_q[r];
                2'd2:    cur_hits[3*r + 2] = row_sync_q[r];
                default: ;
            endcase
        end
        frame_hits = acc_q | cur_hits;
        code       = frame_code(frame_hits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '0;
            row_sync_q <= '0;
        end else begin
            row_meta_q <= key_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Prescaler and column both freeze while disabled so scanning resumes in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            col_idx_q <= 2'd0;
            key_col_q <= 3'b001;
        end else if (enable) begin
            if (tick) begin
                presc_q   <= '0;
                col_idx_q <= (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
                key_col_q <= {key_col_q[1:0], key_col_q[2]};
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            multi_q <= 1'b0;
        end else if (!enable) begin
            acc_q   <= '0;
            multi_q <= 1'b0;
        end else if (tick) begin
            acc_q <= frame_end ? '0 : frame_hits;
            if (frame_end) begin
                multi_q <= (code == KEY_MULTI);
            end
        end
    end

    key_debounce_fsm #(
        .DEB_FRAMES(DEB_FRAMES)
    ) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_valid(frame_end),
        .frame_code (code),
        .key_data   (key_data),
        .key_valid  (key_valid),
        .cnt        (deb_cnt)
    );

    // The count is cleared whenever it reaches DEB_FRAMES, so it always stays below it.
    cnt_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        deb_cnt < 4'(DEB_FRAMES));

    assign key_col   = key_col_q;
    assign multi_key = multi_q;

endmodule
